// File: rtl/lidar_bitstream_pkg.sv
// rtl/lidar_bitstream_pkg.sv - shared constants and types for the LiDAR bitstream reader
package lidar_bitstream_pkg;

    localparam int LIDAR_DATA_W = 64;
    localparam int LIDAR_WIN_W  = 512;
    localparam int LIDAR_BEATS  = LIDAR_WIN_W / LIDAR_DATA_W;

    typedef logic [LIDAR_WIN_W-1:0] lidar_window_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_e;

endpackage

// File: rtl/lidar_window_reg.sv
// rtl/lidar_window_reg.sv - one-entry output window register with valid/ready hold and packet counter
module lidar_window_reg #(
    parameter int WIN_W = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIN_W-1:0] win,
    input  logic [3:0]       beats,
    input  logic             first,
    input  logic             last,
    output logic [WIN_W-1:0] m_bitstream,
    output logic [3:0]       m_beats,
    output logic             m_first,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [15:0]      pkt_count
);

    logic [WIN_W-1:0] data_q, data_d;
    logic [3:0]       beats_q, beats_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic [15:0]      pkt_q, pkt_d;
    logic             drain;

    always_comb begin
        data_d  = data_q;
        beats_d = beats_q;
        first_d = first_q;
        last_d  = last_q;
        valid_d = valid_q;
        drain   = valid_q && m_ready;
        pkt_d   = pkt_q + {15'd0, drain && last_q};
        if (drain) begin
            valid_d = 1'b0;
        end
        // A load on the draining edge keeps m_valid high for back-to-back windows.
        if (load) begin
            data_d  = win;
            beats_d = beats;
            first_d = first;
            last_d  = last;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            beats_q <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            data_q  <= data_d;
            beats_q <= beats_d;
            first_q <= first_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign m_bitstream = data_q;
    assign m_beats     = beats_q;
    assign m_first     = first_q;
    assign m_last      = last_q;
    assign m_valid     = valid_q;
    assign pkt_count   = pkt_q;

endmodule

// File: rtl/lidar_bitstream_packer.sv
// rtl/lidar_bitstream_packer.sv - packs 64-bit beats into MSB-first 512-bit windows with packet framing
module lidar_bitstream_packer
    import lidar_bitstream_pkg::*;
#(
    parameter int DATA_W = LIDAR_DATA_W,
    parameter int WIN_W  = LIDAR_WIN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [WIN_W-1:0]  m_bitstream,
    output logic [3:0]        m_beats,
    output logic              m_first,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       pkt_count
);

    localparam int BEATS = WIN_W / DATA_W;
    localparam int IDX_W = $clog2(BEATS);

    packer_state_e    state_q, state_d;
    logic [WIN_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             in_packet_q, in_packet_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             s_ready_q, s_ready_d;

    logic             load;
    logic [WIN_W-1:0] ld_win;
    logic [WIN_W-1:0] beat_win;
    logic             cur_first;
    logic             out_free;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        idx_d       = idx_q;
        in_packet_d = in_packet_q;
        first_d     = first_q;
        last_d      = last_q;
        load        = 1'b0;
        ld_win      = buf_q;
        out_free    = !m_valid || m_ready;
        // Buffer slots are zero after every clear, so OR-ing places the beat and keeps padding zero.
        beat_win    = buf_q | ({s_data, {(WIN_W-DATA_W){1'b0}}} >> (idx_q * DATA_W));
        cur_first   = (idx_q == '0) ? !in_packet_q : first_q;
        case (state_q)
            FILL: begin
                if (s_valid && s_ready_q) begin
                    in_packet_d = 1'b1;
                    first_d     = cur_first;
                    last_d      = s_last;
                    if (idx_q == IDX_W'(BEATS-1) || s_last) begin
                        if (out_free) begin
                            load        = 1'b1;
                            ld_win      = beat_win;
                            buf_d       = '0;
                            idx_d       = '0;
                            in_packet_d = !s_last;
                        end else begin
                            buf_d   = beat_win;
                            state_d = HOLD;
                        end
                    end else begin
                        buf_d = beat_win;
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    load        = 1'b1;
                    buf_d       = '0;
                    idx_d       = '0;
                    in_packet_d = !last_q;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        s_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            buf_q       <= '0;
            idx_q       <= '0;
            in_packet_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            s_ready_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            in_packet_q <= in_packet_d;
            first_q     <= first_d;
            last_q      <= last_d;
            s_ready_q   <= s_ready_d;
        end
    end

    assign s_ready = s_ready_q;

    lidar_window_reg #(
        .WIN_W(WIN_W)
    ) u_window_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .win         (ld_win),
        .beats       (4'(idx_q) + 4'd1),
        .first       (state_q == HOLD ? first_q : cur_first),
        .last        (state_q == HOLD ? last_q : s_last),
        .m_bitstream (m_bitstream),
        .m_beats     (m_beats),
        .m_first     (m_first),
        .m_last      (m_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .pkt_count   (pkt_count)
    );

endmodule
